// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial wide adder.
package nibble_serial_adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // A single-nibble build still needs a 1-bit index register.
   function automatic int idx_width(input int nibbles);
      return (nibbles > 1) ? $clog2(nibbles) : 1;
   endfunction

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit ripple-carry slice built from full-adder cells.
module nibble_add4
   import nibble_serial_adder_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                cout
);

   logic [NIBBLE_W:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit slice, one nibble per cycle, LSB first.
// Define NIBBLE_SERIAL_ADDER_SUB_EN to add the sub port (A-B via ~B and carry-in 1).
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int IDX_W   = idx_width(NIBBLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              carry_q, carry_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic              cout_q, cout_d;

   logic [WIDTH-1:0]    b_cap;
   logic                c_cap;
   logic [NIBBLE_W-1:0] sl_a, sl_b, sl_sum;
   logic                sl_cout;
   logic                last_nib;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
   assign b_cap = sub ? ~op_b : op_b;
   assign c_cap = sub ? 1'b1  : cin;
`else
   assign b_cap = op_b;
   assign c_cap = cin;
`endif

   assign sl_a     = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
   assign sl_b     = b_q[idx_q*NIBBLE_W +: NIBBLE_W];
   assign last_nib = (idx_q == LAST_IDX);

   nibble_add4 u_slice (
      .a    (sl_a),
      .b    (sl_b),
      .cin  (carry_q),
      .sum  (sl_sum),
      .cout (sl_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid)  state_d = RUN;
         RUN:     if (last_nib)  state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q != IDLE);
   end

   always_comb begin
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      unique case (state_q)
         IDLE: if (in_valid) begin
            a_d     = op_a;
            b_d     = b_cap;
            carry_d = c_cap;
            idx_d   = '0;
         end
         RUN: begin
            sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = sl_sum;
            carry_d = sl_cout;
            idx_d   = idx_q + 1'b1;
            // Wrap the index on the last nibble so it never walks past the operand.
            if (last_nib) begin
               cout_d = sl_cout;
               idx_d  = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule
